game_timer_ctrl: RTL and testbench

//  Sequencer for the on-screen game countdown timer. Produces the BCD tens/ones

---
 rtl/game_timer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// Countdown sequencer for the on-screen game timer: BCD digits, warning blink,
// and run/expire status. All outputs come straight from registers.
module game_timer_ctrl #(
    parameter int CYCLES_PER_SEC = 31_500_000,
    parameter int START_SECONDS  = 99,
    parameter int WARN_SECONDS   = 10,
    parameter int BONUS_SECONDS  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startGame,
    input  logic       pauseGame,
    input  logic       addTime,
    output logic [3:0] timerTens,
    output logic [3:0] timerOnes,
    output logic       digitsVisible,
    output logic       timerRunning,
    output logic       timerExpired,
    output logic       timeUp,
    output logic       secTick
);

    localparam int PW = $clog2(CYCLES_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CYCLES_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CYCLES_PER_SEC / 2);
    localparam logic [3:0]    START_T    = 4'(START_SECONDS / 10);
    localparam logic [3:0]    START_O    = 4'(START_SECONDS % 10);
    localparam logic [3:0]    WARN_T     = 4'(WARN_SECONDS / 10);
    localparam logic [3:0]    WARN_O     = 4'(WARN_SECONDS % 10);
    localparam logic [4:0]    BONUS_T    = 5'(BONUS_SECONDS / 10);
    localparam logic [4:0]    BONUS_O    = 5'(BONUS_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_PAUSED,
        ST_EXPIRED
    } state_t;

    // BCD add of the bonus and/or decrement by one, saturated at 99 only after
    // both are applied so that 99 + bonus - 1 still yields 99.
    function automatic logic [7:0] bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                            input logic add, input logic dec);
        logic [4:0] t;
        logic [4:0] o;
        t = {1'b0, tens};
        o = {1'b0, ones};
        if (add) begin
            o = o + BONUS_O;
            if (o > 5'd9) begin
                o = o - 5'd10;
                t = t + 5'd1;
            end
            t = t + BONUS_T;
        end
        if (dec && (t != 5'd0 || o != 5'd0)) begin
            if (o == 5'd0) begin
                o = 5'd9;
                t = t - 5'd1;
            end else begin
                o = o - 5'd1;
            end
        end
        if (t > 5'd9) begin
            t = 5'd9;
            o = 5'd9;
        end
        return {t[3:0], o[3:0]};
    endfunction

    function automatic logic in_warn(input logic [3:0] tens, input logic [3:0] ones);
        return (tens < WARN_T) || (tens == WARN_T && ones <= WARN_O);
    endfunction

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_vis;
    logic          r_running;
    logic          r_expired;
    logic          r_time_up;
    logic          r_sec_tick;

    state_t        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [7:0]    w_bcd_nxt;
    logic          w_tick;
    logic          w_vis_nxt;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_bcd_nxt   = {r_tens, r_ones};
        w_tick      = 1'b0;
        if (startGame) begin
            w_state_nxt = ST_RUNNING;
            w_presc_nxt = '0;
            w_bcd_nxt   = {START_T, START_O};
        end else begin
            case (r_state)
                ST_RUNNING: begin
                    if (pauseGame) begin
                        w_bcd_nxt   = bcd_step(r_tens, r_ones, addTime, 1'b0);
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_tick      = (r_presc == PRESC_MAX);
                        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                        w_bcd_nxt   = bcd_step(r_tens, r_ones, addTime, w_tick);
                        if (w_bcd_nxt == 8'h00) begin
                            w_state_nxt = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    w_bcd_nxt = bcd_step(r_tens, r_ones, addTime, 1'b0);
                    if (!pauseGame) begin
                        w_state_nxt = ST_RUNNING;
                    end
                end
                default: ;
            endcase
        end
    end

    // Blink phase is derived from the next prescaler so it lines up with the
    // registered digits: visible for the first half of each second.
    assign w_vis_nxt = !((w_state_nxt == ST_RUNNING) && in_warn(w_bcd_nxt[7:4], w_bcd_nxt[3:0]))
                       || (w_presc_nxt < PRESC_HALF);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_tens     <= START_T;
            r_ones     <= START_O;
            r_vis      <= 1'b1;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
            r_time_up  <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_tens     <= w_bcd_nxt[7:4];
            r_ones     <= w_bcd_nxt[3:0];
            r_vis      <= w_vis_nxt;
            r_running  <= (w_state_nxt == ST_RUNNING);
            r_expired  <= (w_state_nxt == ST_EXPIRED);
            r_time_up  <= (w_state_nxt == ST_EXPIRED) && (r_state != ST_EXPIRED);
            r_sec_tick <= w_tick;
        end
    end

    assign timerTens     = r_tens;
    assign timerOnes     = r_ones;
    assign digitsVisible = r_vis;
    assign timerRunning  = r_running;
    assign timerExpired  = r_expired;
    assign timeUp        = r_time_up;
    assign secTick       = r_sec_tick;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: a second-level model predicts each
// cycle's outputs, and a monitor compares them one clock later.
module tb_game_timer_ctrl;

    localparam int CPS   = 4;
    localparam int START = 3;
    localparam int WARN  = 2;
    localparam int BONUS = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    typedef struct {
        int tens;
        int ones;
        int vis;
        int run;
        int expd;
        int tu;
        int tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startGame = 1'b0;
    logic       pauseGame = 1'b0;
    logic       addTime = 1'b0;
    logic [3:0] timerTens;
    logic [3:0] timerOnes;
    logic       digitsVisible;
    logic       timerRunning;
    logic       timerExpired;
    logic       timeUp;
    logic       secTick;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int m_st = M_IDLE;
    int m_val = START;
    int m_presc = 0;

    game_timer_ctrl #(
        .CYCLES_PER_SEC(CPS),
        .START_SECONDS (START),
        .WARN_SECONDS  (WARN),
        .BONUS_SECONDS (BONUS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startGame    (startGame),
        .pauseGame    (pauseGame),
        .addTime      (addTime),
        .timerTens    (timerTens),
        .timerOnes    (timerOnes),
        .digitsVisible(digitsVisible),
        .timerRunning (timerRunning),
        .timerExpired (timerExpired),
        .timeUp       (timeUp),
        .secTick      (secTick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    function automatic int min99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Called at a falling edge: drives inputs for the next rising edge and
    // records the outputs the model predicts after that edge.
    task automatic step(input bit rst, input bit st, input bit pz, input bit ad);
        exp_t e;
        bit   tick;
        bit   was_exp;
        tick      = 1'b0;
        was_exp   = (m_st == M_EXP);
        reset     = rst;
        startGame = st;
        pauseGame = pz;
        addTime   = ad;
        if (rst) begin
            m_st = M_IDLE;
            m_val = START;
            m_presc = 0;
        end else if (st) begin
            m_st = M_RUN;
            m_val = START;
            m_presc = 0;
        end else if (m_st == M_RUN) begin
            if (pz) begin
                if (ad) m_val = min99(m_val + BONUS);
                m_st = M_PAUSE;
            end else begin
                tick = (m_presc == CPS - 1);
                m_presc = (m_presc + 1) % CPS;
                m_val = ad ? min99(m_val + BONUS - int'(tick)) : m_val - int'(tick);
                if (m_val == 0) m_st = M_EXP;
            end
        end else if (m_st == M_PAUSE) begin
            if (ad) m_val = min99(m_val + BONUS);
            if (!pz) m_st = M_RUN;
        end
        e.tens = m_val / 10;
        e.ones = m_val % 10;
        e.vis  = (m_st == M_RUN && m_val <= WARN) ? int'(m_presc < CPS / 2) : 1;
        e.run  = int'(m_st == M_RUN);
        e.expd = int'(m_st == M_EXP);
        e.tu   = int'(m_st == M_EXP && !was_exp);
        e.tick = int'(tick);
        q.push_back(e);
        @(negedge clk);
    endtask

    // Idle-run until the model reaches the given value and prescaler count.
    task automatic run_until(input int val, input int presc, input int budget);
        int n;
        n = 0;
        while (!(m_val == val && m_presc == presc) && n < budget) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (!(m_val == val && m_presc == presc)) begin
            n_fail++;
            $display("FAIL run_until: reached value %0d presc %0d, wanted %0d/%0d", m_val, m_presc, val, presc);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("timerTens", 32'(timerTens), e.tens);
                check("timerOnes", 32'(timerOnes), e.ones);
                check("digitsVisible", 32'(digitsVisible), e.vis);
                check("timerRunning", 32'(timerRunning), e.run);
                check("timerExpired", 32'(timerExpired), e.expd);
                check("timeUp", 32'(timeUp), e.tu);
                check("secTick", 32'(secTick), e.tick);
            end
        end
    end

    initial begin : driver
        bit pz;
        @(negedge clk);
        // Reset state, then a full countdown to expiry.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        // Restart from EXPIRED, then freeze at 02 with prescaler 1.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_until(2, 1, 20);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        // addTime coincident with the wrap from 01.
        run_until(1, 3, 20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        // startGame beats pauseGame; then climb to 98 and saturate at 99.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (19) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        run_until(99, 3, 20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Reset mid-run at 01, then addTime in IDLE has no effect.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_until(1, 1, 20);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        // Randomised traffic.
        pz = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) pz = !pz;
            step($urandom_range(299) == 0, $urandom_range(59) == 0, pz, $urandom_range(39) == 0);
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, wanted 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
